mem_scan_display: RTL and testbench

- Parametrised successor to the lab word-memory with a byte-select LED readout.
- Synchronous-write/synchronous-read RAM with per-byte write enables.
- Self-clearing after reset, plus an auto-scan mode that steps the read address so stored contents cycle on the LEDs.
- Sits between board switches/buttons and the LED bank.

---
 rtl/mem_scan_display.sv | 117 +++++++++++
 tb/tb_mem_scan_display.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_scan_display.sv
// Byte-enabled word RAM with self-clear after reset, a registered read port and
// an LED lane readout that can either follow a manual address or auto-scan memory.
module mem_scan_display #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LED_W    = 8,
    parameter int unsigned SCAN_DIV = 4,
    localparam int unsigned LANES   = DATA_W / LED_W,
    localparam int unsigned SW_W    = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int unsigned BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [BE_W-1:0]   mem_be,
    input  logic              mem_write,
    input  logic [SW_W-1:0]   sw,
    input  logic              scan_en,
    output logic [LED_W-1:0]  led,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   scan_ptr;
    logic [DIV_W-1:0]    div;
    logic [DATA_W-1:0]   rdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   ra;
    logic [DATA_W-1:0]   wr_word;
    logic [DATA_W-1:0]   rd_word;

    // Byte-merged write word; also forwarded to the read port on a same-address hit.
    always_comb begin
        wr_word = mem[mem_addr];
        for (int b = 0; b < int'(BE_W); b++) begin
            if (mem_be[b]) begin
                wr_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        ra      = scan_en ? scan_ptr : mem_addr;
        rd_word = (mem_write && (ra == mem_addr)) ? wr_word : mem[ra];
    end

    // RAM array: cleared word-by-word in CLEAR, byte-enabled writes in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (mem_write) begin
                mem[mem_addr] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            busy     <= 1'b1;
            rdata    <= '0;
            cur_addr <= '0;
            scan_ptr <= '0;
            div      <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == {ADDR_W{1'b1}}) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    rdata    <= rd_word;
                    cur_addr <= ra;
                    // Manual mode parks the scan pointer on mem_addr so a scan starts there.
                    if (!scan_en) begin
                        scan_ptr <= mem_addr;
                        div      <= '0;
                    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
                        div      <= '0;
                        scan_ptr <= scan_ptr + ADDR_W'(1);
                    end else begin
                        div      <= div + DIV_W'(1);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Lane select is combinational so the LEDs react to sw without a clock.
    always_comb begin
        led = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (sw == SW_W'(i)) begin
                led = rdata[i*LED_W +: LED_W];
            end
        end
    end

endmodule

// File: tb/tb_mem_scan_display.sv
// Directed + randomized checks of mem_scan_display against an array-based memory model.
module tb_mem_scan_display;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_write;
    logic [1:0]  sw;
    logic        scan_en;
    logic [7:0]  led;
    logic [5:0]  cur_addr;
    logic        busy;

    // Reduced-parameter instance
    logic        rst2;
    logic [3:0]  mem_addr2;
    logic [15:0] mem_wdata2;
    logic [1:0]  mem_be2;
    logic        mem_write2;
    logic [0:0]  sw2;
    logic        scan_en2;
    logic [7:0]  led2;
    logic [3:0]  cur_addr2;
    logic        busy2;

    mem_scan_display dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_write(mem_write), .sw(sw), .scan_en(scan_en),
        .led(led), .cur_addr(cur_addr), .busy(busy)
    );

    mem_scan_display #(.ADDR_W(4), .DATA_W(16), .LED_W(8), .SCAN_DIV(1)) dut2 (
        .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_be(mem_be2), .mem_write(mem_write2), .sw(sw2), .scan_en(scan_en2),
        .led(led2), .cur_addr(cur_addr2), .busy(busy2)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m  [64];
    logic [15:0] m2 [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] w, input int s);
        return w[s*8 +: 8];
    endfunction

    initial begin
        logic [31:0] w;
        int          a;
        int          s;
        int          exp_a;

        rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_be = '0; mem_write = 1'b0;
        sw = '0; scan_en = 1'b0;
        rst2 = 1'b1; mem_addr2 = '0; mem_wdata2 = '0; mem_be2 = '0; mem_write2 = 1'b0;
        sw2 = '0; scan_en2 = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_led", 64'(led), 64'(0));
        chk("rst_cur", 64'(cur_addr), 64'(0));

        // Clear sequence: busy for exactly 64 edges, write to addr 5 ignored
        rst = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            if (i >= 10 && i <= 12) begin
                mem_write = 1'b1; mem_addr = 6'd5; mem_wdata = 32'hFFFF_FFFF; mem_be = 4'hF;
            end else begin
                mem_write = 1'b0; mem_addr = '0;
            end
            tick();
            chk($sformatf("clr_busy_%0d", i), 64'(busy), 64'(i < 64));
            if (i < 64) chk($sformatf("clr_led_%0d", i), 64'(led), 64'(0));
        end
        for (int k = 0; k < 64; k++) m[k] = '0;

        // Every word reads back zero on every lane
        for (int k = 0; k < 64; k++) begin
            mem_addr = 6'(k);
            tick();
            chk($sformatf("zero_cur_%0d", k), 64'(cur_addr), 64'(k));
            for (int l = 0; l < 4; l++) begin
                sw = 2'(l);
                #1;
                chk($sformatf("zero_led_%0d_%0d", k, l), 64'(led), 64'(0));
            end
        end

        // Byte-enable write and same-cycle lane select
        sw = '0;
        mem_addr = '0; mem_write = 1'b1; mem_wdata = 32'h1122_3344; mem_be = 4'hF;
        m[0] = merge(m[0], mem_wdata, mem_be);
        tick();
        mem_wdata = 32'hAABB_CCDD; mem_be = 4'b0101;
        m[0] = merge(m[0], mem_wdata, mem_be);
        tick();
        mem_write = 1'b0;
        tick();
        chk("be_model", 64'(m[0]), 64'h11BB_33DD);
        for (int l = 0; l < 4; l++) begin
            sw = 2'(l);
            #1;
            chk($sformatf("be_led_%0d", l), 64'(led), 64'(lane(32'h11BB_33DD, l)));
        end

        // One-cycle read latency
        sw = '0;
        mem_addr = 6'd1; mem_write = 1'b1; mem_wdata = 32'h0000_00A5; mem_be = 4'hF;
        m[1] = mem_wdata;
        tick();
        mem_write = 1'b0; mem_addr = '0;
        tick();
        chk("lat_cur0", 64'(cur_addr), 64'(0));
        chk("lat_led0", 64'(led), 64'h DD);
        mem_addr = 6'd1;
        #1;
        chk("lat_hold", 64'(led), 64'h DD);
        tick();
        chk("lat_led1", 64'(led), 64'h A5);
        chk("lat_cur1", 64'(cur_addr), 64'(1));

        // Write-first collision
        mem_addr = 6'd2; mem_write = 1'b1; mem_wdata = 32'h1234_5678; mem_be = 4'hF;
        m[2] = mem_wdata;
        tick();
        mem_wdata = 32'h0000_005A; mem_be = 4'b0001;
        m[2] = merge(m[2], mem_wdata, mem_be);
        tick();
        mem_write = 1'b0;
        chk("col_b0", 64'(led), 64'h5A);
        sw = 2'd1;
        #1;
        chk("col_b1", 64'(led), 64'h56);

        // Randomized manual-mode traffic
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 63));
            s = int'($urandom_range(0, 3));
            mem_addr  = 6'(a);
            sw        = 2'(s);
            mem_write = 1'($urandom_range(0, 1));
            mem_wdata = $urandom;
            mem_be    = 4'($urandom_range(0, 15));
            if (mem_write) m[a] = merge(m[a], mem_wdata, mem_be);
            w = m[a];
            tick();
            chk($sformatf("rnd_cur_%0d", i), 64'(cur_addr), 64'(a));
            chk($sformatf("rnd_led_%0d", i), 64'(led), 64'(lane(w, s)));
        end
        mem_write = 1'b0;

        // Scan: preload mem[k]=k, start at 62, four cycles per step
        for (int k = 0; k < 64; k++) begin
            mem_addr = 6'(k); mem_write = 1'b1; mem_wdata = 32'(k); mem_be = 4'hF;
            m[k] = 32'(k);
            tick();
        end
        mem_write = 1'b0; mem_addr = 6'd62; sw = '0; scan_en = 1'b0;
        tick();
        scan_en = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            exp_a = (62 + k / 4) % 64;
            chk($sformatf("scan_cur_%0d", k), 64'(cur_addr), 64'(exp_a));
            chk($sformatf("scan_led_%0d", k), 64'(led), 64'(lane(m[exp_a], 0)));
        end
        scan_en = 1'b0; mem_addr = 6'd17;
        tick();
        chk("scan_off_cur", 64'(cur_addr), 64'(17));
        chk("scan_off_led", 64'(led), 64'(17));

        // Reset during a scan at address 30
        mem_addr = 6'd30;
        tick();
        scan_en = 1'b1;
        tick(); tick();
        chk("mid_cur30", 64'(cur_addr), 64'(30));
        rst = 1'b1;
        tick();
        chk("mid_busy", 64'(busy), 64'(1));
        chk("mid_led", 64'(led), 64'(0));
        rst = 1'b0; scan_en = 1'b0; mem_addr = 6'd40;
        for (int i = 1; i <= 64; i++) begin
            tick();
            chk($sformatf("mid_clr_busy_%0d", i), 64'(busy), 64'(i < 64));
        end
        for (int k = 0; k < 64; k++) m[k] = '0;
        tick();
        scan_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("mid_scan_cur_%0d", k), 64'(cur_addr), 64'(40 + k / 4));
            chk($sformatf("mid_scan_led_%0d", k), 64'(led), 64'(0));
        end
        scan_en = 1'b0;

        // Reduced instance: 16-word clear, 1-bit sw, scan every cycle with wrap
        rst2 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("p_clr_busy_%0d", i), 64'(busy2), 64'(i < 16));
        end
        for (int k = 0; k < 16; k++) begin
            mem_addr2 = 4'(k); mem_write2 = 1'b1; mem_be2 = 2'b11;
            mem_wdata2 = 16'({8'(k + 8'h30), 8'(k ^ 8'hA0)});
            m2[k] = mem_wdata2;
            tick();
        end
        mem_write2 = 1'b0; mem_addr2 = 4'd14;
        tick();
        scan_en2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s = k % 2;
            sw2 = 1'(s);
            tick();
            exp_a = (14 + k) % 16;
            chk($sformatf("p_scan_cur_%0d", k), 64'(cur_addr2), 64'(exp_a));
            chk($sformatf("p_scan_led_%0d", k), 64'(led2), 64'(m2[exp_a][s*8 +: 8]));
        end
        scan_en2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
